md_unit: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div and divu over multiple cycles, and owns the HI/LO registers.
- Services mthi and mtlo writes.
- Reads of HI/LO (mfhi/mflo) are combinational from its outputs.
- Drives a hazard output that the stall unit ORs into its global stall, so D-stage md instructions wait while the unit is occupied.

---
 rtl/md_unit_pkg.sv | 25 ++
 rtl/md_unit.sv | 120 ++++++++++++
 tb/tb_md_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit: md_op encodings,
// default busy durations and a small decode helper.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W           = 5;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic isMulDiv(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage. Owns HI/LO, runs mult/div ops
// for a fixed number of cycles and raises md_stall so D-stage md
// instructions wait until the unit is free.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_md_use,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        md_stall
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] counter_q, counter_d;
  logic [31:0]         pendHi_q, pendHi_d;
  logic [31:0]         pendLo_q, pendLo_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;

  md_op_e              op;
  logic                startMulDiv;
  logic signed [63:0]  prodS;
  logic [63:0]         prodU;
  logic [31:0]         divisor;
  logic                divOverflow;
  logic [31:0]         quoS, remS, quoU, remU;

  assign op          = md_op_e'(md_op);
  assign startMulDiv = start & isMulDiv(md_op);
  assign busy        = (counter_q != '0);
  assign md_stall    = D_md_use & (busy | startMulDiv);
  assign HI          = hi_q;
  assign LO          = lo_q;

  // Behavioural arithmetic. The divisor is forced to 1 when B is zero so
  // the operators never see a zero divisor; that result is never used.
  assign prodS       = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prodU       = {32'd0, A} * {32'd0, B};
  assign divisor     = (B == 32'd0) ? 32'd1 : B;
  assign divOverflow = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign quoS        = divOverflow ? 32'h8000_0000 : $unsigned($signed(A) / $signed(divisor));
  assign remS        = divOverflow ? 32'd0         : $unsigned($signed(A) % $signed(divisor));
  assign quoU        = A / divisor;
  assign remU        = A % divisor;

  // Next-state: count down while running and commit the pending result on
  // the last cycle; when idle, accept a new op. A divide by zero latches
  // the current HI/LO as its pending result so the commit leaves them as is
  // (HI/LO cannot change while busy, so this copy stays exact).
  always_comb begin
    counter_d = counter_q;
    pendHi_d  = pendHi_q;
    pendLo_d  = pendLo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (busy) begin
      counter_d = counter_q - MD_CNT_W'(1);
      if (counter_q == MD_CNT_W'(1)) begin
        hi_d = pendHi_q;
        lo_d = pendLo_q;
      end
    end else if (start) begin
      case (op)
        MD_MULT: begin
          pendHi_d  = prodS[63:32];
          pendLo_d  = prodS[31:0];
          counter_d = MULT_LOAD;
        end
        MD_MULTU: begin
          pendHi_d  = prodU[63:32];
          pendLo_d  = prodU[31:0];
          counter_d = MULT_LOAD;
        end
        MD_DIV: begin
          pendHi_d  = (B == 32'd0) ? hi_q : remS;
          pendLo_d  = (B == 32'd0) ? lo_q : quoS;
          counter_d = DIV_LOAD;
        end
        MD_DIVU: begin
          pendHi_d  = (B == 32'd0) ? hi_q : remU;
          pendLo_d  = (B == 32'd0) ? lo_q : quoU;
          counter_d = DIV_LOAD;
        end
        MD_MTHI: hi_d = A;
        MD_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  // State registers; reset clears everything, dropping any in-flight result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_q <= '0;
      pendHi_q  <= '0;
      pendLo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      counter_q <= counter_d;
      pendHi_q  <= pendHi_d;
      pendLo_q  <= pendLo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit. Expected HI/LO pairs are queued when an
// op is issued and popped once the unit goes idle again.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        dMdUse;
  logic        busy;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        mdStall;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [63:0] sbQ[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .md_op    (mdOp),
    .A        (opA),
    .B        (opB),
    .D_md_use (dMdUse),
    .busy     (busy),
    .HI       (hiOut),
    .LO       (loOut),
    .md_stall (mdStall)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Issue a multi-cycle op, check stall/busy each cycle, then pop and
  // compare the result once busy drops. injectAt>0 drives a stray MULT 2x2
  // in that busy cycle, which the unit must ignore.
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic dUse, input int cycles,
                               input int injectAt, input logic [31:0] expHi, input logic [31:0] expLo);
    int          busyCount;
    logic [63:0] exp;
    sbQ.push_back({expHi, expLo});
    @(negedge clk);
    start  = 1'b1;
    mdOp   = op;
    opA    = a;
    opB    = b;
    dMdUse = dUse;
    #1 checkOutput({name, ".stallStart"}, 32'(mdStall), 32'(dUse));
    @(posedge clk);
    #1 start = 1'b0;
    mdOp = MD_NONE;
    busyCount = 0;
    while (busyCount < cycles + 4) begin
      @(negedge clk);
      if (!busy) break;
      busyCount++;
      checkOutput({name, ".stallBusy"}, 32'(mdStall), 32'(dUse));
      if (busyCount == injectAt) begin
        start = 1'b1;
        mdOp  = MD_MULT;
        opA   = 32'd2;
        opB   = 32'd2;
        @(posedge clk);
        #1 start = 1'b0;
        mdOp = MD_NONE;
      end
    end
    checkOutput({name, ".busyCycles"}, 32'(busyCount), 32'(cycles));
    checkOutput({name, ".busyDone"}, 32'(busy), 32'd0);
    checkOutput({name, ".stallIdle"}, 32'(mdStall), 32'd0);
    exp = sbQ.pop_front();
    checkOutput({name, ".HI"}, hiOut, exp[63:32]);
    checkOutput({name, ".LO"}, loOut, exp[31:0]);
    dMdUse = 1'b0;
  endtask

  // Issue a single-cycle (or no-effect) op with D_md_use high; it must not
  // stall, never raise busy, and update HI/LO on the following cycle.
  task automatic applyQuick(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] expHi, input logic [31:0] expLo);
    logic [63:0] exp;
    sbQ.push_back({expHi, expLo});
    @(negedge clk);
    start  = 1'b1;
    mdOp   = op;
    opA    = a;
    opB    = 32'hDEAD_BEEF;
    dMdUse = 1'b1;
    #1 checkOutput({name, ".stallStart"}, 32'(mdStall), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    mdOp = MD_NONE;
    @(negedge clk);
    checkOutput({name, ".busy"}, 32'(busy), 32'd0);
    exp = sbQ.pop_front();
    checkOutput({name, ".HI"}, hiOut, exp[63:32]);
    checkOutput({name, ".LO"}, loOut, exp[31:0]);
    dMdUse = 1'b0;
  endtask

  // Test sequence.
  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    mdOp    = MD_NONE;
    opA     = '0;
    opB     = '0;
    dMdUse  = 1'b0;

    @(negedge clk);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.HI", hiOut, 32'd0);
    checkOutput("reset.LO", loOut, 32'd0);
    reset_n = 1'b1;

    applyStimulus("mult",    MD_MULT,  32'hFFFF_FFFE, 32'd3,         1'b1, 5,  0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    applyStimulus("multu",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5,  0, 32'hFFFF_FFFE, 32'h0000_0001);
    applyStimulus("div",     MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b1, 10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus("divuZ",   MD_DIVU,  32'd7,         32'd0,         1'b0, 10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus("divOvf",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 0, 32'h0000_0000, 32'h8000_0000);
    applyStimulus("divu",    MD_DIVU,  32'd100,       32'd7,         1'b1, 10, 0, 32'd2,         32'd14);
    applyStimulus("divZ",    MD_DIV,   32'd55,        32'd0,         1'b0, 10, 0, 32'd2,         32'd14);
    applyStimulus("divBusy", MD_DIV,   32'd100,       32'hFFFF_FFF9, 1'b1, 10, 2, 32'd2,         32'hFFFF_FFF2);

    applyQuick("mthi", MD_MTHI, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFF2);
    applyQuick("mtlo", MD_MTLO, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0);
    applyQuick("none", MD_NONE, 32'h1111_1111, 32'h1234_5678, 32'h9ABC_DEF0);
    applyQuick("rsvd", MD_RSVD, 32'h2222_2222, 32'h1234_5678, 32'h9ABC_DEF0);

    // Reset in cycle 3 of a MULT 5x5: state clears at once, result is lost.
    @(negedge clk);
    start = 1'b1;
    mdOp  = MD_MULT;
    opA   = 32'd5;
    opB   = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    mdOp = MD_NONE;
    repeat (3) @(negedge clk);
    checkOutput("rstMid.busyBefore", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rstMid.busy", 32'(busy), 32'd0);
    checkOutput("rstMid.HI", hiOut, 32'd0);
    checkOutput("rstMid.LO", loOut, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checkOutput("rstMid.noResult", loOut, 32'd0);
      checkOutput("rstMid.idle", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
